// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory/addressing unit.
package mem_pkg;
  localparam logic [7:0] STACK_PAGE_DEF = 8'hFF;
  localparam logic [7:0] IO_PAGE_DEF = 8'hFE;
  localparam int BP_AW = 16;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_IMM,
    SRC_PC
  } busSrc_t;

  typedef struct packed {
    logic en;
    logic [BP_AW-1:0] addr;
  } bpEntry_t;
endpackage

// File: rtl/mem_addr_unit_bp_unit.sv
// Breakpoint register file with registered, sticky
// lowest-index hit detection.
module bp_unit
  import mem_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int NUM_BP = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_bpWrite,
  input  logic [2:0]      i_bpIndex,
  input  logic [PC_W-1:0] i_bpAddr,
  input  logic            i_bpEnable,
  input  logic            i_bpClear,
  output logic            o_bpHit,
  output logic [2:0]      o_bpHitIndex
);
  bpEntry_t entries [NUM_BP];
  logic anyMatch;
  logic [2:0] lowIdx;

  always_comb begin
    anyMatch = 1'b0;
    lowIdx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (entries[i].en &&
          entries[i].addr == BP_AW'(i_pc)) begin
        anyMatch = 1'b1;
        lowIdx = 3'(i);
      end
    end
  end

  // Out-of-range indices match no slot and are dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        entries[i] <= '0;
      end
    end else if (i_bpWrite) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (i_bpIndex == 3'(i)) begin
          entries[i].en <= i_bpEnable;
          entries[i].addr <= BP_AW'(i_bpAddr);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bpHit <= 1'b0;
      o_bpHitIndex <= '0;
    end else if (anyMatch) begin
      o_bpHit <= 1'b1;
      if (!o_bpHit) o_bpHitIndex <= lowIdx;
    end else if (i_bpClear) begin
      o_bpHit <= 1'b0;
      o_bpHitIndex <= '0;
    end
  end
endmodule

// File: rtl/mem_addr_unit.sv
// CPU memory/addressing block: PC, SP, MAR, instruction
// register, address generation and bus arbitration.
module mem_addr_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W = 16,
  parameter int ROM_AW = 15,
  parameter int SP_W = 8,
  parameter int NUM_BP = 4,
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEF,
  parameter logic [7:0] IO_PAGE = IO_PAGE_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_busEn,
  output logic              o_busConflict,
  input  logic              i_ctrlPCNEn,
  input  logic              i_ctrlPCLoadN,
  input  logic              i_ctrlPCFromImm,
  input  logic              i_ctrlMemPCToRamN,
  input  logic              i_ctrlSpNEn,
  input  logic              i_ctrlSpUp,
  input  logic              i_ctrlInstrNWE,
  input  logic              i_ctrlInstrNOE,
  input  logic              i_ctrlRamNOE,
  input  logic              i_ctrlRamNWE,
  input  logic              i_ctrlMemMar0NWE,
  input  logic              i_ctrlMemMar1NWE,
  input  logic              i_ctrlMarInc,
  input  logic              i_ctrlMemInstrImmToRamAddr,
  output logic [7:0]        o_instrCode,
  output logic [ROM_AW-1:0] o_romAddress,
  input  logic [23:0]       i_romData,
  output logic [PC_W:0]     o_ramAddress,
  input  logic [DATA_W-1:0] i_ramData,
  input  logic [DATA_W-1:0] i_ram2Data,
  output logic [DATA_W-1:0] o_ramData,
  output logic [DATA_W-1:0] o_ram2Data,
  output logic              o_ramWE,
  output logic              o_ramCE,
  output logic              o_ioSelect,
  output logic              o_ioNOE,
  output logic              o_ioNWE,
  output logic [7:0]        o_ioAddress,
  input  logic              i_bpWrite,
  input  logic [2:0]        i_bpIndex,
  input  logic [PC_W-1:0]   i_bpAddr,
  input  logic              i_bpEnable,
  input  logic              i_bpClear,
  input  logic              i_flagClear,
  output logic              o_bpHit,
  output logic [2:0]        o_bpHitIndex,
  output logic              o_spOverflow,
  output logic              o_spUnderflow
);
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] mar;
  logic [PC_W-1:0] instrImm;
  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] srcAddr;
  logic [DATA_W-1:0] sel;
  logic spOvf;
  logic spUnf;
  logic ramEn;
  logic immEn;
  logic pcEn;
  busSrc_t busSrc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc <= '0;
    end else if (!i_ctrlPCNEn) begin
      if (i_ctrlPCLoadN) pc <= pc + PC_W'(1);
      else if (i_ctrlPCFromImm) pc <= instrImm;
      else pc <= {i_ram2Data, i_bus};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_instrCode <= '0;
      instrImm <= '0;
    end else if (!i_ctrlInstrNWE) begin
      o_instrCode <= i_romData[23:16];
      instrImm <= i_romData[PC_W-1:0];
    end
  end

  // A byte write in the same cycle takes precedence over increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mar <= '0;
    end else if (!i_ctrlMemMar0NWE || !i_ctrlMemMar1NWE) begin
      if (!i_ctrlMemMar0NWE) mar[DATA_W-1:0] <= i_bus;
      if (!i_ctrlMemMar1NWE) mar[PC_W-1:DATA_W] <= i_bus;
    end else if (i_ctrlMarInc) begin
      mar <= mar + PC_W'(1);
    end
  end

  assign spOvf = !i_ctrlSpNEn && i_ctrlSpUp && (sp == '1);
  assign spUnf = !i_ctrlSpNEn && !i_ctrlSpUp && (sp == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sp <= '0;
      o_spOverflow <= 1'b0;
      o_spUnderflow <= 1'b0;
    end else begin
      if (!i_ctrlSpNEn) begin
        sp <= i_ctrlSpUp ? sp + SP_W'(1) : sp - SP_W'(1);
      end
      if (spOvf) o_spOverflow <= 1'b1;
      else if (i_flagClear) o_spOverflow <= 1'b0;
      if (spUnf) o_spUnderflow <= 1'b1;
      else if (i_flagClear) o_spUnderflow <= 1'b0;
    end
  end

  assign srcAddr = i_ctrlMemInstrImmToRamAddr ? instrImm : mar;
  assign sel = srcAddr[PC_W-1:DATA_W];

  always_comb begin
    o_ramAddress = {1'b0, srcAddr};
    if (sel == STACK_PAGE) begin
      o_ramAddress = {1'b1, sp, srcAddr[DATA_W-1:0]};
    end
  end

  assign o_ioSelect = (sel == IO_PAGE);
  assign o_ramCE = ~o_ioSelect;
  assign o_ioAddress = o_ramAddress[7:0];
  assign o_ramWE = ~i_ctrlRamNWE;
  assign o_ioNOE = i_ctrlRamNOE;
  assign o_ioNWE = i_ctrlRamNWE;
  assign o_romAddress = pc[ROM_AW-1:0];

  assign ramEn = ~i_ctrlRamNOE;
  assign immEn = ~i_ctrlInstrNOE;
  assign pcEn = ~i_ctrlMemPCToRamN;

  always_comb begin
    busSrc = SRC_NONE;
    if (ramEn) busSrc = SRC_RAM;
    else if (immEn) busSrc = SRC_IMM;
    else if (pcEn) busSrc = SRC_PC;
  end

  always_comb begin
    o_bus = '0;
    unique case (busSrc)
      SRC_RAM: o_bus = i_ramData;
      SRC_IMM: o_bus = instrImm[DATA_W-1:0];
      SRC_PC:  o_bus = pc[DATA_W-1:0];
      default: o_bus = '0;
    endcase
  end

  assign o_busEn = (busSrc != SRC_NONE);
  assign o_busConflict = (ramEn & immEn) | (ramEn & pcEn) |
                         (immEn & pcEn);
  assign o_ramData = pcEn ? pc[DATA_W-1:0] : i_bus;
  assign o_ram2Data = pcEn ? pc[PC_W-1:DATA_W] : '0;

  bp_unit #(
    .PC_W(PC_W),
    .NUM_BP(NUM_BP)
  ) uBp (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_pc(pc),
    .i_bpWrite(i_bpWrite),
    .i_bpIndex(i_bpIndex),
    .i_bpAddr(i_bpAddr),
    .i_bpEnable(i_bpEnable),
    .i_bpClear(i_bpClear),
    .o_bpHit(o_bpHit),
    .o_bpHitIndex(o_bpHitIndex)
  );
endmodule
